divider_burst_ctrl: RTL and testbench

Controller that sequences a programmable divide-by-N tick generator. It accepts a divisor and burst length through a valid/ready configuration port, runs the divider on `start`, and emits exactly the requested number of divided ticks. It then signals `done` and returns to a re-armable state. It sits between the control/CSR logic and any datapath that needs a gated, counted clock-enable, and generalises the fixed divide-by-3 pulse FSM to programmable, bursted operation.

---
 rtl/divider_pkg.sv | 18 +
 rtl/divider_burst_ctrl_if.sv | 34 +++
 rtl/divn_counter.sv | 36 +++
 rtl/divider_burst_ctrl.sv | 83 ++++++++
 tb/tb_divider_burst_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// divider_pkg: shared FSM state type and default widths. Rev 1.0
// ----------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_BW = 8;

endpackage
`default_nettype wire

// File: rtl/divider_burst_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------
// divider_burst_ctrl_if: config handshake, control and status bundle. Rev 1.0
// ----------------------------------------------------------------
interface divider_burst_ctrl_if
  import divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int BW = DEF_BW
) ();

  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_div;
  logic [BW-1:0] cfg_count;
  logic          start;
  logic          stop;
  logic          busy;
  logic          tick;
  logic          done;
  logic [BW-1:0] remaining;

  modport master (
    output cfg_valid, cfg_div, cfg_count, start, stop,
    input  cfg_ready, busy, tick, done, remaining
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_count, start, stop,
    output cfg_ready, busy, tick, done, remaining
  );

endinterface
`default_nettype wire

// File: rtl/divn_counter.sv
`default_nettype none
// ----------------------------------------------------------------
// divn_counter: phase counter wrapping at div-1, tick on the last phase. Rev 1.0
// ----------------------------------------------------------------
module divn_counter
  import divider_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          clr,
  input  wire logic          en,
  input  wire logic [DW-1:0] div,
  output logic               tick
);

  logic [DW-1:0] phase;
  logic          last;

  // div is never 0 here, so div-1 cannot underflow
  assign last = (phase == (div - DW'(1)));
  assign tick = en && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= last ? '0 : phase + DW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/divider_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// divider_burst_ctrl: configurable, bursted divide-by-N tick sequencer. Rev 1.0
// ----------------------------------------------------------------
module divider_burst_ctrl
  import divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int BW = DEF_BW
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  divider_burst_ctrl_if.slave bus
);

  ctrl_state_t   state;
  logic [DW-1:0] div_q;
  logic [BW-1:0] count_q;
  logic [BW-1:0] remaining;
  logic          xfer;
  logic          running;
  logic          tick;

  assign running = (state == RUN);
  assign xfer    = bus.cfg_valid && bus.cfg_ready;

  divn_counter #(.DW(DW)) u_divn (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!running || bus.stop),
    .en      (running),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_q     <= DW'(1);
      count_q   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          // a config transfer takes precedence over a same-cycle start
          if (xfer) begin
            div_q   <= (bus.cfg_div == '0) ? DW'(1) : bus.cfg_div;
            count_q <= bus.cfg_count;
            state   <= READY;
          end else if (state == READY && bus.start) begin
            remaining <= count_q;
            state     <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            remaining <= '0;
            state     <= READY;
          end else if (tick && count_q != '0) begin
            remaining <= remaining - BW'(1);
            if (remaining == BW'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= READY;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready = (state == IDLE) || (state == READY);
  assign bus.busy      = running;
  assign bus.done      = (state == DONE);
  assign bus.tick      = tick;
  assign bus.remaining = remaining;

endmodule
`default_nettype wire

// File: tb/tb_divider_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_divider_burst_ctrl: directed scenarios with hand-computed expectations. Rev 1.0
// ----------------------------------------------------------------
module tb_divider_burst_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  divider_burst_ctrl_if #(.DW(8), .BW(8)) bus ();

  divider_burst_ctrl #(.DW(8), .BW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // packed view {tick,busy,done,cfg_ready,remaining}
  function automatic logic [11:0] obs();
    return {bus.tick, bus.busy, bus.done, bus.cfg_ready, bus.remaining};
  endfunction

  function automatic logic [11:0] pk(input logic t, input logic b, input logic d,
                                     input logic r, input int rem);
    return {t, b, d, r, 8'(rem)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] d, input logic [7:0] c);
    int n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = d;
    bus.cfg_count = c;
    while (bus.cfg_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_accept timeout: cfg_ready=%b required 1", bus.cfg_ready);
    end
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic start_burst();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    bus.cfg_valid = 1'b0; bus.cfg_div = '0; bus.cfg_count = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    e = pk(0, 0, 0, 1, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_state: got %03h required %03h", obs(), e);
    end
    reset_n = 1'b1;
    step();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL after_reset: got %03h required %03h", obs(), e);
    end
    start_burst();
    for (int i = 1; i <= 3; i++) begin
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL start_in_idle c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_burst_basic();
    logic [11:0] e;
    configure(8'd3, 8'd4);
    start_burst();
    for (int i = 1; i <= 14; i++) begin
      e = pk((i <= 12) && (i % 3 == 0), i <= 12, i == 13, i >= 14,
             (i <= 12) ? 4 - (i - 1) / 3 : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL burst_basic c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_continuous_stop();
    logic [11:0] e;
    int ticks = 0;
    configure(8'd5, 8'd0);
    start_burst();
    for (int i = 1; i <= 23; i++) begin
      e = pk(i % 5 == 0, 1, 0, 0, 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL continuous c%0d: got %03h required %03h", i, obs(), e);
      end
      if (bus.tick === 1'b1) ticks++;
      if (i < 23) step();
    end
    vectors++;
    if (ticks != 4) begin
      miscompares++;
      $display("FAIL continuous_ticks: got %0d required 4", ticks);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = pk(0, 0, 0, 1, 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL after_stop c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_div_zero();
    logic [11:0] e;
    configure(8'd0, 8'd2);
    start_burst();
    for (int i = 1; i <= 4; i++) begin
      e = pk(i <= 2, i <= 2, i == 3, i == 4, (i <= 2) ? 3 - i : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL div_zero c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_div_255();
    logic [11:0] e;
    configure(8'd255, 8'd1);
    start_burst();
    for (int i = 1; i <= 257; i++) begin
      e = pk(i == 255, i <= 255, i == 256, i == 257, (i <= 255) ? 1 : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL div_255 c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_cfg_with_start();
    logic [11:0] e;
    bus.cfg_valid = 1'b1; bus.cfg_div = 8'd2; bus.cfg_count = 8'd1;
    bus.start = 1'b1;
    step();
    bus.cfg_valid = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = pk(0, 0, 0, 1, 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL cfg_start_no_run c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
    start_burst();
    for (int i = 1; i <= 3; i++) begin
      e = pk(i == 2, i <= 2, i == 3, 0, (i <= 2) ? 1 : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL cfg_start_newcfg c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_stop_final_tick();
    logic [11:0] e;
    configure(8'd2, 8'd2);
    start_burst();
    for (int i = 1; i <= 4; i++) begin
      e = pk(i % 2 == 0, 1, 0, 0, (i <= 2) ? 2 : 1);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL stop_final c%0d: got %03h required %03h", i, obs(), e);
      end
      if (i < 4) step();
    end
    bus.stop = 1'b1;
    #1;
    vectors++;
    if (bus.tick !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_final_tick: tick=%b required 1", bus.tick);
    end
    step();
    bus.stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = pk(0, 0, 0, 1, 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL stop_final_no_done c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_cfg_held_in_run();
    logic [11:0] e;
    configure(8'd3, 8'd2);
    start_burst();
    bus.cfg_valid = 1'b1; bus.cfg_div = 8'd1; bus.cfg_count = 8'd1;
    for (int i = 1; i <= 8; i++) begin
      e = pk((i <= 6) && (i % 3 == 0), i <= 6, i == 7, i == 8,
             (i <= 3) ? 2 : (i <= 6) ? 1 : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL cfg_held c%0d: got %03h required %03h", i, obs(), e);
      end
      if (i < 8) step();
    end
    step();
    bus.cfg_valid = 1'b0;
    start_burst();
    for (int i = 1; i <= 2; i++) begin
      e = pk(i == 1, i == 1, i == 2, 0, (i == 1) ? 1 : 0);
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL cfg_held_newcfg c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [11:0] e;
    configure(8'd4, 8'd10);
    start_burst();
    repeat (3) step();
    e = pk(1, 1, 0, 0, 10);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL pre_reset c4: got %03h required %03h", obs(), e);
    end
    #2;
    reset_n = 1'b0;
    #1;
    e = pk(0, 0, 0, 1, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %03h required %03h", obs(), e);
    end
    step();
    step();
    reset_n = 1'b1;
    start_burst();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL post_reset_idle c%0d: got %03h required %03h", i, obs(), e);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_burst_basic();
    test_continuous_stop();
    test_div_zero();
    test_div_255();
    test_cfg_with_start();
    test_stop_final_tick();
    test_cfg_held_in_run();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
